// File: rtl/core_bus_arbiter.sv
// Two-master, one-slave Wishbone-classic round-robin arbiter for the core_* memory port.
// Optional watchdog enabled by defining ARBITER_TIMEOUT_EN.
module core_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [SEL_WIDTH-1:0]  m0_sel,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [SEL_WIDTH-1:0]  m1_sel,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  core_cyc,
  output logic                  core_stb,
  output logic                  core_we,
  output logic [SEL_WIDTH-1:0]  core_sel,
  output logic [ADDR_WIDTH-1:0] core_addr,
  output logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_ack
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   req0, req1, own1, own_cyc, tmo;

  assign req0    = m0_cyc & m0_stb;
  assign req1    = m1_cyc & m1_stb;
  assign own1    = (state == GNT1);
  assign own_cyc = own1 ? m1_cyc : m0_cyc;

  assign m0_rdata = core_data_in;
  assign m1_rdata = core_data_in;

`ifdef ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;

  // Every grant is entered from IDLE, so clearing in IDLE clears on grant entry.
  always_ff @(posedge clk_core) begin
    if (rst_core || state == IDLE) wd_cnt <= '0;
    else if (!core_ack)            wd_cnt <= wd_cnt + 16'd1;
  end

  assign tmo = (state != IDLE) && (wd_cnt == TO_LAST) && !core_ack;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant)) state_nxt = GNT0;
        else if (req1)                     state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (core_ack || !own_cyc || tmo) begin
          state_nxt      = IDLE;
          last_grant_nxt = own1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are also held quiet while reset is asserted so a reset cycle
  // during a grant never leaks an ack or err for the aborted transfer.
  always_comb begin
    core_cyc      = 1'b0;
    core_stb      = 1'b0;
    core_we       = 1'b0;
    core_sel      = '0;
    core_addr     = '0;
    core_data_out = '0;
    m0_ack        = 1'b0;
    m1_ack        = 1'b0;
    m0_err        = 1'b0;
    m1_err        = 1'b0;
    if (!rst_core && state != IDLE) begin
      core_cyc      = own_cyc & ~tmo;
      core_stb      = (own1 ? m1_stb : m0_stb) & ~tmo;
      core_we       = own1 ? m1_we    : m0_we;
      core_sel      = own1 ? m1_sel   : m0_sel;
      core_addr     = own1 ? m1_addr  : m0_addr;
      core_data_out = own1 ? m1_wdata : m0_wdata;
      m0_ack        = ~own1 & core_ack & m0_cyc;
      m1_ack        =  own1 & core_ack & m1_cyc;
      m0_err        = ~own1 & tmo;
      m1_err        =  own1 & tmo;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: directed vector table, hand sequences,
// and randomized traffic against a transaction-level reference model.
module tb_core_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
`ifdef ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [AW-1:0] A0 = 32'h0000_0100;
  localparam logic [AW-1:0] A1 = 32'h8000_0004;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic          rst_core;
  logic          m_cyc[2], m_stb[2], m_we[2];
  logic [SW-1:0] m_sel[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wdata[2];
  logic [DW-1:0] m0_rdata, m1_rdata, core_data_out, core_data_in;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          core_cyc, core_stb, core_we, core_ack;
  logic [SW-1:0] core_sel;
  logic [AW-1:0] core_addr;

  core_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_sel(m_sel[0]),
    .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_sel(m_sel[1]),
    .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel),
    .core_addr(core_addr), .core_data_out(core_data_out),
    .core_data_in(core_data_in), .core_ack(core_ack)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: who holds the bus (-1 = nobody), who was served last,
  // and how many unacknowledged cycles the current holder has waited.
  int owner = -1;
  int last  = 1;
  int wcnt  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit model_tmo();
    return TO_EN && owner >= 0 && wcnt == TO - 1 && !core_ack;
  endfunction

  task automatic model_check();
    logic          e_cyc, e_stb, e_we, t;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [1:0]    e_ack, e_err;
    {e_cyc, e_stb, e_we, e_sel, e_addr, e_wd, e_ack, e_err} = '0;
    if (!rst_core && owner >= 0) begin
      t            = model_tmo();
      e_cyc        = m_cyc[owner] & ~t;
      e_stb        = m_stb[owner] & ~t;
      e_we         = m_we[owner];
      e_sel        = m_sel[owner];
      e_addr       = m_addr[owner];
      e_wd         = m_wdata[owner];
      e_ack[owner] = core_ack & m_cyc[owner];
      e_err[owner] = t;
    end
    check("outputs",
          {core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out, m1_ack, m0_ack, m1_err, m0_err},
          {e_cyc, e_stb, e_we, e_sel, e_addr, e_wd, e_ack, e_err});
    check("rdata", {m0_rdata, m1_rdata}, {core_data_in, core_data_in});
  endtask

  task automatic model_step();
    bit r0, r1;
    if (rst_core) begin
      owner = -1; last = 1; wcnt = 0;
    end else if (owner < 0) begin
      r0 = m_cyc[0] & m_stb[0];
      r1 = m_cyc[1] & m_stb[1];
      if (r0 && r1) owner = 1 - last;
      else if (r0)  owner = 0;
      else if (r1)  owner = 1;
      wcnt = 0;
    end else if (core_ack || !m_cyc[owner] || model_tmo()) begin
      last  = owner;
      owner = -1;
    end else begin
      wcnt++;
    end
  endtask

  task automatic sample();
    @(negedge clk_core);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk_core);
    model_step();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic drive(input bit r, input bit r0, input bit r1, input bit a);
    rst_core = r;
    m_cyc[0] = r0; m_stb[0] = r0;
    m_cyc[1] = r1; m_stb[1] = r1;
    core_ack = a;
  endtask

  typedef struct {
    bit rst; bit r0; bit r1; bit ack;
    int exp_own; bit exp_a0; bit exp_a1;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{1, 0, 0, 0, -1, 0, 0};
    vt[1]  = '{1, 1, 1, 0, -1, 0, 0};
    vt[2]  = '{0, 1, 1, 0, -1, 0, 0};
    vt[3]  = '{0, 1, 1, 1,  0, 1, 0};
    vt[4]  = '{0, 1, 1, 1, -1, 0, 0};
    vt[5]  = '{0, 1, 1, 1,  1, 0, 1};
    vt[6]  = '{0, 1, 1, 1, -1, 0, 0};
    vt[7]  = '{0, 1, 1, 1,  0, 1, 0};
    vt[8]  = '{0, 1, 1, 0, -1, 0, 0};
    vt[9]  = '{0, 1, 1, 0,  1, 0, 0};
    vt[10] = '{0, 1, 1, 1,  1, 0, 1};
    vt[11] = '{0, 0, 0, 0, -1, 0, 0};

    for (int m = 0; m < 2; m++) begin
      m_we[m] = 1'b0; m_sel[m] = 4'hF; m_wdata[m] = 32'h1111_0000 + 32'(m);
    end
    m_addr[0] = A0;
    m_addr[1] = A1;
    core_data_in = 32'h1234_5678;
    drive(1, 0, 0, 0);

    // Reset, first-tie priority, strict alternation, ack ignored in IDLE.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rst, vt[i].r0, vt[i].r1, vt[i].ack);
      sample();
      check($sformatf("vec%0d", i),
            {core_cyc, core_addr, m0_ack, m1_ack},
            {vt[i].exp_own >= 0,
             (vt[i].exp_own == 0) ? A0 : (vt[i].exp_own == 1) ? A1 : 32'h0,
             vt[i].exp_a0, vt[i].exp_a1});
      advance();
    end

    // m1 write with three wait states.
    m_we[1] = 1'b1; m_sel[1] = 4'b0011; m_wdata[1] = 32'hDEAD_BEEF;
    drive(0, 0, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("m1_write_wait",
            {core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out, m1_ack, m0_ack},
            {1'b1, 1'b1, 1'b1, 4'b0011, A1, 32'hDEAD_BEEF, 1'b0, 1'b0});
      advance();
    end
    drive(0, 0, 1, 1);
    sample();
    check("m1_write_ack", {core_cyc, core_addr, m1_ack, m0_ack}, {1'b1, A1, 1'b1, 1'b0});
    advance();
    drive(0, 0, 0, 0);
    sample();
    check("m1_write_done", {core_cyc, m1_ack}, 2'b00);
    advance();
    m_we[1] = 1'b0; m_sel[1] = 4'hF;

    // m0 aborts mid-grant; ack in the abort cycle is dropped; m1 then wins.
    drive(0, 1, 0, 0);
    tick();
    drive(0, 1, 1, 0);
    sample();
    check("abort_grant0", {core_cyc, core_addr}, {1'b1, A0});
    advance();
    drive(0, 0, 1, 1);
    sample();
    check("abort_no_ack", {m0_ack, m1_ack, core_cyc}, 3'b000);
    advance();
    drive(0, 0, 1, 0);
    sample();
    check("abort_idle", core_cyc, 1'b0);
    advance();
    drive(0, 0, 1, 1);
    sample();
    check("abort_then_m1", {core_cyc, core_addr, m1_ack}, {1'b1, A1, 1'b1});
    advance();

    // Reset during GNT1 with ack pending.
    drive(0, 0, 1, 0);
    tick();
    sample();
    check("rst_gnt1", {core_cyc, core_addr}, {1'b1, A1});
    advance();
    drive(1, 0, 1, 1);
    sample();
    check("rst_no_ack", {m1_ack, m1_err, m0_ack, core_cyc, core_stb}, 5'b0);
    advance();
    drive(0, 1, 1, 0);
    sample();
    check("rst_then_idle", {core_cyc, core_stb, core_addr}, {2'b00, 32'h0});
    advance();
    drive(0, 1, 1, 1);
    sample();
    check("rst_tie_m0", {core_cyc, core_addr, m0_ack}, {1'b1, A0, 1'b1});
    advance();
    drive(0, 0, 0, 0);
    tick();

`ifdef ARBITER_TIMEOUT_EN
    // Watchdog fires in the 8th unacknowledged GNT0 cycle; ack in that cycle wins.
    drive(0, 1, 0, 0);
    tick();
    for (int i = 1; i <= TO; i++) begin
      sample();
      check($sformatf("wd_cycle%0d", i), {m0_err, core_stb, core_cyc},
            (i == TO) ? 3'b100 : 3'b011);
      advance();
    end
    drive(0, 0, 0, 0);
    sample();
    check("wd_idle", {core_cyc, m0_err}, 2'b00);
    advance();
    drive(0, 1, 0, 0);
    tick();
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) drive(0, 1, 0, 1);
      sample();
      if (i == TO) check("wd_ack_wins", {m0_ack, m0_err, core_stb}, 3'b101);
      advance();
    end
    drive(0, 0, 0, 0);
    tick();
`endif

    // Randomized traffic against the model; second phase acks rarely.
    for (int i = 0; i < 900; i++) begin
      rst_core = ($urandom_range(0, 59) == 0);
      for (int m = 0; m < 2; m++) begin
        m_cyc[m]   = ($urandom_range(0, 3) != 0);
        m_stb[m]   = ($urandom_range(0, 3) != 0);
        m_we[m]    = 1'($urandom);
        m_sel[m]   = 4'($urandom);
        m_addr[m]  = $urandom;
        m_wdata[m] = $urandom;
      end
      if (i >= 600) begin
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
      end
      core_ack     = (i < 600) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      core_data_in = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
